// File: rtl/nts_tx_buffer.sv
// nts_tx_buffer: transmit-side packet buffer.
// The engine writes 8/16/32/64-bit big-endian values at any byte alignment
// (read-modify-write into a single-port RAM). On a transmit command the
// packet is streamed from byte 0 as 64-bit words over valid/ready.
module nts_tx_buffer #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_clear,
    output logic                  o_access_port_wait,
    input  logic [ADDR_WIDTH+2:0] i_access_port_addr,
    input  logic [2:0]            i_access_port_wordsize,
    input  logic                  i_access_port_wr_en,
    input  logic [63:0]           i_access_port_wr_data,
    input  logic                  i_transmit,
    input  logic [ADDR_WIDTH+3:0] i_transmit_bytes,
    output logic                  o_tx_valid,
    output logic [63:0]           o_tx_data,
    output logic [3:0]            o_tx_bytes,
    output logic                  o_tx_last,
    input  logic                  i_tx_ready,
    output logic                  o_busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_RD_A  = 3'd1;
    localparam logic [2:0] ST_WR_MRG_A = 3'd2;
    localparam logic [2:0] ST_WR_RD_B  = 3'd3;
    localparam logic [2:0] ST_WR_MRG_B = 3'd4;
    localparam logic [2:0] ST_TX_FETCH = 3'd5;
    localparam logic [2:0] ST_TX_LOAD  = 3'd6;
    localparam logic [2:0] ST_TX_SEND  = 3'd7;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Largest legal packet: the whole buffer.
    localparam logic [ADDR_WIDTH+3:0] MAX_BYTES = {1'b1, {(ADDR_WIDTH+3){1'b0}}};

    logic [2:0]            state_reg, state_next;
    logic                  busy_reg;
    logic [ADDR_WIDTH+2:0] wr_addr_reg;
    logic [1:0]            wr_ws_reg;
    logic [63:0]           wr_data_reg;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic [ADDR_WIDTH:0]   last_idx_reg;
    logic [3:0]            tail_bytes_reg;
    logic                  tx_valid_reg;
    logic [63:0]           tx_data_reg;
    logic [3:0]            tx_bytes_reg;
    logic                  tx_last_reg;

    logic [63:0]           mem [0:DEPTH-1];
    logic [63:0]           ram_q;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [63:0]           ram_wdata;

    // Wordsize codes 4..7 behave like 64-bit writes.
    logic [1:0]            ws_in;
    logic [ADDR_WIDTH+3:0] len_clamped;
    logic [ADDR_WIDTH+3:0] len_m1;
    assign ws_in       = i_access_port_wordsize[2] ? 2'd3 : i_access_port_wordsize[1:0];
    assign len_clamped = (i_transmit_bytes > MAX_BYTES) ? MAX_BYTES : i_transmit_bytes;
    assign len_m1      = len_clamped - 1'b1;

    // Merge geometry: a 16-byte window covering word A (upper half) and
    // word B (lower half). Data and byte mask are left-aligned, then shifted
    // right by the starting lane.
    logic [2:0]            wr_lane;
    logic [3:0]            wr_nbytes;
    logic [6:0]            wr_shift;
    logic [63:0]           data_left, mask_left;
    logic [127:0]          win_data, win_mask;
    logic                  wr_span;
    logic [ADDR_WIDTH-1:0] word_a, word_b;
    logic [63:0]           merged_a, merged_b;

    assign wr_lane   = wr_addr_reg[2:0];
    assign wr_nbytes = 4'd1 << wr_ws_reg;
    assign wr_shift  = 7'd64 - {wr_nbytes, 3'b000};
    assign data_left = wr_data_reg << wr_shift;
    assign mask_left = {64{1'b1}} << wr_shift;
    assign win_data  = {data_left, 64'd0} >> {wr_lane, 3'b000};
    assign win_mask  = {mask_left, 64'd0} >> {wr_lane, 3'b000};
    assign wr_span   = ({1'b0, wr_lane} + wr_nbytes) > 4'd8;
    assign word_a    = wr_addr_reg[ADDR_WIDTH+2:3];
    assign word_b    = word_a + 1'b1;
    assign merged_a  = (ram_q & ~win_mask[127:64]) | (win_data[127:64] & win_mask[127:64]);
    assign merged_b  = (ram_q & ~win_mask[63:0])   | (win_data[63:0]   & win_mask[63:0]);

    // Output word preparation: zero the lanes beyond the valid byte count.
    logic       is_last;
    logic [3:0] bytes_load;
    logic [63:0] tx_word_masked;
    assign is_last    = ({1'b0, ptr_reg} == last_idx_reg);
    assign bytes_load = is_last ? tail_bytes_reg : 4'd8;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign tx_word_masked[63-8*gi -: 8] = (4'(gi) < bytes_load) ? ram_q[63-8*gi -: 8] : 8'h00;
        end
    endgenerate

    // Next-state logic; abort/reset always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_access_port_wr_en)
                    state_next = ST_WR_RD_A;
                else if (i_transmit && (i_transmit_bytes != '0))
                    state_next = ST_TX_FETCH;
            end
            ST_WR_RD_A:  state_next = ST_WR_MRG_A;
            ST_WR_MRG_A: state_next = wr_span ? ST_WR_RD_B : ST_IDLE;
            ST_WR_RD_B:  state_next = ST_WR_MRG_B;
            ST_WR_MRG_B: state_next = ST_IDLE;
            ST_TX_FETCH: state_next = ST_TX_LOAD;
            ST_TX_LOAD:  state_next = ST_TX_SEND;
            ST_TX_SEND: begin
                if (i_tx_ready)
                    state_next = tx_last_reg ? ST_IDLE : ST_TX_FETCH;
            end
            default:     state_next = ST_IDLE;
        endcase
        if (i_clear || i_areset)
            state_next = ST_IDLE;
    end

    // RAM port steering: write words during merge states, pointer otherwise.
    always_comb begin
        ram_addr  = ptr_reg;
        ram_we    = 1'b0;
        ram_wdata = merged_a;
        case (state_reg)
            ST_WR_RD_A:  ram_addr = word_a;
            ST_WR_MRG_A: begin
                ram_addr = word_a;
                ram_we   = !(i_clear || i_areset);
            end
            ST_WR_RD_B:  ram_addr = word_b;
            ST_WR_MRG_B: begin
                ram_addr  = word_b;
                ram_wdata = merged_b;
                ram_we    = !(i_clear || i_areset);
            end
            default: ;
        endcase
    end

    // Single-port RAM with registered read; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    // Command capture and word pointer; only accepted while IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_areset && !i_clear) begin
            if (state_reg == ST_IDLE) begin
                if (i_access_port_wr_en) begin
                    wr_addr_reg <= i_access_port_addr;
                    wr_ws_reg   <= ws_in;
                    wr_data_reg <= i_access_port_wr_data;
                end else if (i_transmit && (i_transmit_bytes != '0)) begin
                    ptr_reg        <= '0;
                    last_idx_reg   <= len_m1[ADDR_WIDTH+3:3];
                    tail_bytes_reg <= {1'b0, len_m1[2:0]} + 4'd1;
                end
            end else if (state_reg == ST_TX_SEND && i_tx_ready && !tx_last_reg) begin
                ptr_reg <= ptr_reg + 1'b1;
            end
        end
    end

    // State register and stream outputs.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            tx_bytes_reg <= '0;
            tx_last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            if (i_clear) begin
                tx_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_TX_LOAD: begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= tx_word_masked;
                        tx_bytes_reg <= bytes_load;
                        tx_last_reg  <= is_last;
                    end
                    ST_TX_SEND: begin
                        if (i_tx_ready)
                            tx_valid_reg <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_access_port_wait = busy_reg;
    assign o_busy             = busy_reg;
    assign o_tx_valid         = tx_valid_reg;
    assign o_tx_data          = tx_data_reg;
    assign o_tx_bytes         = tx_bytes_reg;
    assign o_tx_last          = tx_last_reg;

endmodule

// File: tb/tb_nts_tx_buffer.sv
// Testbench for nts_tx_buffer: directed plan steps plus random writes and
// transmits, checked against a byte-array model of the packet buffer.
module tb_nts_tx_buffer;

    localparam int AW     = 8;
    localparam int NBYTES = 8 << AW;

    logic          clk = 1'b0;
    logic          areset, clear;
    logic          ap_wait;
    logic [AW+2:0] ap_addr;
    logic [2:0]    ap_ws;
    logic          ap_wr_en;
    logic [63:0]   ap_wr_data;
    logic          transmit;
    logic [AW+3:0] transmit_bytes;
    logic          tx_valid;
    logic [63:0]   tx_data;
    logic [3:0]    tx_bytes;
    logic          tx_last;
    logic          tx_ready;
    logic          busy;

    always #5 clk = ~clk;

    nts_tx_buffer #(.ADDR_WIDTH(AW)) dut (
        .i_clk                  (clk),
        .i_areset               (areset),
        .i_clear                (clear),
        .o_access_port_wait     (ap_wait),
        .i_access_port_addr     (ap_addr),
        .i_access_port_wordsize (ap_ws),
        .i_access_port_wr_en    (ap_wr_en),
        .i_access_port_wr_data  (ap_wr_data),
        .i_transmit             (transmit),
        .i_transmit_bytes       (transmit_bytes),
        .o_tx_valid             (tx_valid),
        .o_tx_data              (tx_data),
        .o_tx_bytes             (tx_bytes),
        .o_tx_last              (tx_last),
        .i_tx_ready             (tx_ready),
        .o_busy                 (busy)
    );

    logic [7:0]  ref_mem [0:NBYTES-1];
    logic [63:0] obs_words [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: N = 2^ws bytes, most significant byte at addr, wrapping at the end.
    task automatic model_write(input logic [AW+2:0] addr, input logic [2:0] ws, input logic [63:0] data);
        int n;
        n = 1 << ((ws > 3'd3) ? 3 : int'(ws));
        for (int i = 0; i < n; i++)
            ref_mem[(int'(addr) + i) % NBYTES] = data[8*(n-1-i) +: 8];
    endtask

    // Model: word k of a packet of lc bytes, unused lanes zero.
    function automatic logic [63:0] exp_word(input int k, input int lc);
        logic [63:0] w;
        int nb;
        w  = '0;
        nb = lc - 8*k;
        if (nb > 8) nb = 8;
        for (int j = 0; j < nb; j++)
            w[63-8*j -: 8] = ref_mem[8*k + j];
        return w;
    endfunction

    task automatic wait_valid(output int cnt);
        cnt = 1;
        while (!tx_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic do_write(input logic [AW+2:0] addr, input logic [2:0] ws, input logic [63:0] data);
        int n, cnt, exp_cnt;
        n = 1 << ((ws > 3'd3) ? 3 : int'(ws));
        exp_cnt = (int'(addr[2:0]) + n > 8) ? 4 : 2;
        @(negedge clk);
        ap_wr_en = 1'b1; ap_addr = addr; ap_ws = ws; ap_wr_data = data;
        @(negedge clk);
        ap_wr_en = 1'b0;
        cnt = 0;
        while (ap_wait && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        $display("write addr=%0h ws=%0d data=%h wait_cycles=%0d", addr, ws, data, cnt);
        check("wr_wait_cycles", 64'(cnt), 64'(exp_cnt));
        model_write(addr, ws, data);
    endtask

    // Streams one packet, holding ready low for min..max cycles per word.
    // With poke set, a write and a transmit strobe are thrown at the busy DUT.
    task automatic do_transmit(input int len, input int min_stall, input int max_stall, input bit poke);
        int lc, nw, cnt, stall, eb;
        logic [63:0] ew;
        obs_words.delete();
        lc = (len > NBYTES) ? NBYTES : len;
        nw = (lc + 7) / 8;
        @(negedge clk);
        transmit = 1'b1; transmit_bytes = 12'(len);
        @(negedge clk);
        transmit = 1'b0;
        for (int k = 0; k < nw; k++) begin
            wait_valid(cnt);
            check("tx_latency", 64'(cnt), 64'd3);
            if (!tx_valid) return;
            ew = exp_word(k, lc);
            eb = (k == nw - 1) ? (lc - 8*k) : 8;
            $display("tx word %0d data=%h bytes=%0d last=%0d", k, tx_data, tx_bytes, tx_last);
            check("tx_data", tx_data, ew);
            check("tx_bytes", 64'(tx_bytes), 64'(eb));
            check("tx_last", 64'(tx_last), 64'(k == nw - 1));
            obs_words.push_back(tx_data);
            stall = $urandom_range(max_stall, min_stall);
            for (int s = 0; s < stall; s++) begin
                if (poke && s == 0) begin
                    ap_wr_en = 1'b1; ap_addr = 11'(8*k); ap_ws = 3'd3; ap_wr_data = {$urandom, $urandom};
                    transmit = 1'b1; transmit_bytes = 12'd8;
                end
                @(negedge clk);
                ap_wr_en = 1'b0; transmit = 1'b0;
                check("hold_valid", 64'(tx_valid), 64'd1);
                check("hold_data", tx_data, ew);
                check("hold_bytes", 64'(tx_bytes), 64'(eb));
                check("hold_last", 64'(tx_last), 64'(k == nw - 1));
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        check("tx_end_valid", 64'(tx_valid), 64'd0);
        check("tx_end_busy", 64'(busy), 64'd0);
        check("tx_end_wait", 64'(ap_wait), 64'd0);
    endtask

    initial begin
        int cnt, exp_cnt, n;
        logic [63:0] w;
        logic [AW+2:0] ra;
        logic [2:0] rws;
        logic [63:0] rdata;

        areset = 1'b1; clear = 1'b0; ap_wr_en = 1'b0; ap_addr = '0; ap_ws = '0;
        ap_wr_data = '0; transmit = 1'b0; transmit_bytes = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        check("rst_wait", 64'(ap_wait), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_bytes", 64'(tx_bytes), 64'd0);
        check("rst_last", 64'(tx_last), 64'd0);

        // Give every RAM word a known value so whole-buffer transmits are checkable.
        for (int i = 0; i < (1 << AW); i++)
            do_write(11'(8*i), 3'd3, {$urandom, $urandom});

        // Aligned 64-bit writes, plain 24-byte packet.
        do_write(11'd0,  3'd3, 64'hdeadbeef00000000);
        do_write(11'd8,  3'd3, 64'habad1deac0fef00d);
        do_write(11'd16, 3'd3, 64'h0123456789abcd5f);
        do_write(11'd16, 3'd3, 64'h0123456789abcdef);
        do_transmit(24, 0, 0, 1'b0);
        check("p1_count", 64'(obs_words.size()), 64'd3);
        if (obs_words.size() == 3) begin
            check("p1_w0", obs_words[0], 64'hdeadbeef00000000);
            check("p1_w1", obs_words[1], 64'habad1deac0fef00d);
            check("p1_w2", obs_words[2], 64'h0123456789abcdef);
        end

        // Spanning 32-bit write, short last word.
        do_write(11'd6, 3'd2, 64'h11223344);
        do_transmit(12, 0, 0, 1'b0);
        if (obs_words.size() == 2) begin
            check("p2_w0", obs_words[0], 64'hdeadbeef00001122);
            check("p2_w1", obs_words[1], 64'h33441dea00000000);
        end

        // Byte write and a 16-bit write that wraps past the end of the buffer.
        do_write(11'd23, 3'd0, 64'h5a);
        do_write(11'h7ff, 3'd1, 64'hcafe);
        do_transmit(24, 0, 0, 1'b0);
        if (obs_words.size() == 3) begin
            check("p3_w0", obs_words[0], 64'hfeadbeef00001122);
            check("p3_w2", obs_words[2], 64'h0123456789abcd5a);
        end

        // Oversized length is clamped to the whole buffer.
        do_transmit(4095, 0, 0, 1'b0);
        check("full_count", 64'(obs_words.size()), 64'(NBYTES / 8));
        if (obs_words.size() == NBYTES / 8) begin
            w = obs_words[NBYTES/8 - 1];
            check("wrap_lane7", 64'(w[7:0]), 64'hca);
        end

        // Backpressure of 5 cycles per word, with ignored strobes while busy.
        do_transmit(37, 5, 5, 1'b1);
        check("bp_count", 64'(obs_words.size()), 64'd5);
        do_transmit(40, 0, 0, 1'b0);

        // Abort during word 1 of a 24-byte packet.
        @(negedge clk);
        transmit = 1'b1; transmit_bytes = 12'd24;
        @(negedge clk);
        transmit = 1'b0;
        wait_valid(cnt);
        check("clr_w0_latency", 64'(cnt), 64'd3);
        check("clr_w0_data", tx_data, exp_word(0, 24));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        wait_valid(cnt);
        check("clr_w1_valid", 64'(tx_valid), 64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        $display("clear applied during word 1");
        check("clr_valid", 64'(tx_valid), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_wait", 64'(ap_wait), 64'd0);
        do_transmit(8, 0, 0, 1'b0);

        // Write and transmit strobes together: the write wins, no packet follows.
        @(negedge clk);
        ap_wr_en = 1'b1; ap_addr = 11'd30; ap_ws = 3'd2; ap_wr_data = 64'h99887766;
        transmit = 1'b1; transmit_bytes = 12'd16;
        @(negedge clk);
        ap_wr_en = 1'b0; transmit = 1'b0;
        cnt = 0;
        while (ap_wait && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        $display("simultaneous write+transmit wait_cycles=%0d", cnt);
        check("both_wait_cycles", 64'(cnt), 64'd4);
        model_write(11'd30, 3'd2, 64'h99887766);
        for (int i = 0; i < 6; i++) begin
            check("both_no_tx", 64'(tx_valid), 64'd0);
            @(negedge clk);
        end
        do_transmit(40, 0, 2, 1'b0);

        // Random mix of writes and transmits.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(2, 0) != 0) begin
                ra    = 11'($urandom_range(NBYTES - 1, 0));
                rws   = 3'($urandom_range(7, 0));
                rdata = {$urandom, $urandom};
                do_write(ra, rws, rdata);
            end else begin
                n = $urandom_range(80, 1);
                do_transmit(n, 0, 3, ($urandom_range(1, 0) == 1) && n > 0);
            end
        end

        // Zero-length transmit is ignored.
        @(negedge clk);
        transmit = 1'b1; transmit_bytes = 12'd0;
        @(negedge clk);
        transmit = 1'b0;
        check("zero_len_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check("zero_len_valid", 64'(tx_valid), 64'd0);

        // Reset mid-packet clears outputs but keeps the RAM.
        @(negedge clk);
        transmit = 1'b1; transmit_bytes = 12'd32;
        @(negedge clk);
        transmit = 1'b0;
        wait_valid(cnt);
        check("rst2_valid_before", 64'(tx_valid), 64'd1);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        $display("reset applied during packet");
        check("rst2_valid", 64'(tx_valid), 64'd0);
        check("rst2_data", tx_data, 64'd0);
        check("rst2_bytes", 64'(tx_bytes), 64'd0);
        check("rst2_last", 64'(tx_last), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);
        do_transmit(32, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nts_tx_buffer.md
# nts_tx_buffer

Transmit-side packet buffer for the NTS engine. The engine builds an outgoing packet with byte-addressed, big-endian writes of 8/16/32/64 bits at any alignment through an access port. On command, the block streams the packet as 64-bit words to the transmit FIFO/MAC over a valid/ready interface. It is the write-in, stream-out counterpart of nts_rx_buffer and uses the same byte-address and wordsize encoding.

## Interface
- ADDR_WIDTH, 8, word-address width; RAM is 2^ADDR_WIDTH x 64 bits; byte address is ADDR_WIDTH+3 bits

- i_clk  in  1  clock, all logic on rising edge
- i_areset  in  1  synchronous active-high reset
- i_clear  in  1  synchronous abort: FSMs to IDLE, RAM untouched
- o_access_port_wait  out  1  high while a write or transmit is in progress
- i_access_port_addr  in  ADDR_WIDTH+3  byte address of first (most significant) byte
- i_access_port_wordsize  in  3  0=8, 1=16, 2=32, 3=64 bits; 4..7 treated as 3
- i_access_port_wr_en  in  1  single-cycle write strobe
- i_access_port_wr_data  in  64  right-aligned write data
- i_transmit  in  1  single-cycle start strobe
- i_transmit_bytes  in  ADDR_WIDTH+4  packet length in bytes, sent from byte 0
- o_tx_valid  out  1  output word valid
- o_tx_data  out  64  output word, byte 0 in bits 63:56
- o_tx_bytes  out  4  valid bytes in o_tx_data, 1..8
- o_tx_last  out  1  final word of packet
- i_tx_ready  in  1  sink accepts word when o_tx_valid & i_tx_ready
- o_busy  out  1  FSM not IDLE

## Operation
- Byte b is stored in word b>>3, lane b[2:0]; lane 0 = bits 63:56 (big-endian).
- A write of N = 2^ws bytes places wr_data[8N-1:8N-8] at addr, ..., wr_data[7:0] at addr+N-1. Bytes outside the range are preserved.
- The write spans two words when addr[2:0] + N > 8. The second word is (word+1) mod 2^ADDR_WIDTH, so writes wrap at the end of the buffer.
- RAM is single-port with registered read (1-cycle latency). Every write is a read-modify-write.
- FSM states: IDLE, WR_RD_A, WR_MRG_A, WR_RD_B, WR_MRG_B, TX_FETCH, TX_LOAD, TX_SEND.
- IDLE, wr_en=1: latch addr/ws/data, go to WR_RD_A. i_transmit is ignored in the same cycle, because a write has priority.
- IDLE, i_transmit=1 with bytes≠0: latch length, set word pointer to 0, go to TX_FETCH. If bytes=0, the strobe is ignored. Lengths above 8·2^ADDR_WIDTH are clamped to that value.
- WR_RD_A presents the address. WR_MRG_A merges and writes, then goes to WR_RD_B if the write spans, otherwise IDLE. WR_RD_B and WR_MRG_B do the same for the second word, then go to IDLE.
- TX_FETCH presents the pointer.
- TX_LOAD registers the RAM data into o_tx_data and sets o_tx_valid. It also sets o_tx_bytes to 8, or to len mod 8 (8 if 0) on the last word, and sets o_tx_last when pointer = ceil(len/8)-1. Unused lanes of the last word are driven to 0.
- TX_SEND holds all outputs stable until i_tx_ready.
- On the handshake, clear o_tx_valid. If last, go to IDLE; otherwise increment the pointer and go to TX_FETCH.
- wr_en or i_transmit arriving outside IDLE is ignored; the caller must observe o_access_port_wait.
- i_clear or i_areset: next state IDLE, o_tx_valid=0, the in-flight write is abandoned, and RAM contents are kept. Reset does not initialise RAM.

## Timing
- Reset values: o_access_port_wait=0, o_busy=0, o_tx_valid=0, o_tx_data=0, o_tx_bytes=0, o_tx_last=0.
- o_access_port_wait = o_busy = (state≠IDLE), registered.
- Write: wait rises the cycle after wr_en. It stays high exactly 2 cycles for a non-spanning write and 4 cycles for a spanning one. A new write may be issued in the first cycle wait is low.
- Transmit: o_tx_valid rises 2 cycles after i_transmit is sampled. Each subsequent word becomes valid 2 cycles after the previous handshake, giving a peak rate of 1 word per 3 cycles.
- Data written by a completed write is visible to any later transmit.

## Test plan
- Write 64'hdeadbeef00000000 @0, 64'habad1deac0fef00d @8, 64'h0123456789abcdef @16 (ws=3), each with wait high 2 cycles; transmit 24 → 3 words in order, bytes 8/8/8, last on the third.
- Write ws=2, data 32'h11223344 @6 (spanning, wait high 4 cycles); transmit 12 → deadbeef00001122 (bytes 8), then 33441dea00000000 (bytes 4, last).
- Write ws=0, data 8'h5a @23; ws=1, data 16'hcafe @0x7ff (wraps) → word 255 lane 7 = ca, word 0 = feadbeef00001122; word 2 = 0123456789abcd5a is verified via transmit 24.
- Backpressure: hold i_tx_ready=0 for 5 cycles per word → data/bytes/last stable, no word dropped or duplicated.
- i_clear during TX_SEND of word 1 of a 24-byte packet → o_tx_valid=0 next cycle, IDLE, wait=0; a new transmit 8 returns word 0 unchanged.
- wr_en and i_transmit in the same IDLE cycle → write performed, no tx output; wr_en during transmit → ignored, RAM unchanged.
